// File: rtl/pic_inta_sequencer.sv
// rtl/pic_inta_sequencer.sv - PIC interrupt raise, 8086 two-pulse INTA sequencer and EOI/rotation control
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid, req_level  winning request from the priority resolver
//   inta_n                CPU acknowledge strobe (already synchronous to clk)
//   vec_base              ICW2 T7..T3
//   aeoi, rot_en          automatic-EOI and rotate-on-EOI mode selects
//   eoi_cmd, eoi_specific, eoi_level  one-cycle OCW2 EOI command
//   isr                   current in-service register
//   int_o                 interrupt request to the CPU
//   isr_set, isr_set_level  one-cycle ISR set / IRR clear command
//   isr_clr               one-cycle mask of ISR bits to clear
//   data_out, data_oe     vector byte and bus drive enable
//   prio_base             lowest-priority level
//
// Build option: define PIC_AEOI_EN to build the automatic-EOI clear at the
// end of the acknowledge; without it the aeoi input is ignored.

module pic_inta_sequencer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   input  logic [2:0] req_level,
   input  logic       inta_n,
   input  logic [4:0] vec_base,
   input  logic       aeoi,
   input  logic       rot_en,
   input  logic       eoi_cmd,
   input  logic       eoi_specific,
   input  logic [2:0] eoi_level,
   input  logic [7:0] isr,
   output logic       int_o,
   output logic       isr_set,
   output logic [2:0] isr_set_level,
   output logic [7:0] isr_clr,
   output logic [7:0] data_out,
   output logic       data_oe,
   output logic [2:0] prio_base
);

   typedef enum logic [1:0] {IDLE, PEND, ACK1, ACK2} state_t;

   state_t     state;
   logic       inta_q;
   logic [2:0] lvl;
   logic       spurious;

   logic       fall;
   logic       rise;
   logic       aeoi_fire;
   logic       eoi_hit;
   logic [2:0] eoi_sel;
   logic [7:0] eoi_mask;
   logic [7:0] aeoi_mask;
   logic [2:0] idx;

   assign fall = inta_q & ~inta_n;
   assign rise = ~inta_q & inta_n;

`ifdef PIC_AEOI_EN
   assign aeoi_fire = aeoi & (state == ACK2) & rise & ~spurious;
`else
   logic unused_aeoi;
   assign unused_aeoi = aeoi;
   assign aeoi_fire   = 1'b0;
`endif

   assign aeoi_mask = aeoi_fire ? (8'd1 << lvl) : 8'd0;

   // EOI decode. Non-specific EOI walks from the highest-priority level
   // (prio_base+1) downward in priority and picks the first in-service bit.
   always_comb begin
      eoi_hit  = 1'b0;
      eoi_sel  = eoi_level;
      eoi_mask = 8'd0;
      idx      = 3'd0;
      if (eoi_cmd) begin
         if (eoi_specific) begin
            eoi_hit = 1'b1;
         end else begin
            for (int i = 1; i <= 8; i++) begin
               idx = prio_base + 3'(i);
               if (!eoi_hit && isr[idx]) begin
                  eoi_hit = 1'b1;
                  eoi_sel = idx;
               end
            end
         end
         if (eoi_hit) eoi_mask = 8'd1 << eoi_sel;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         inta_q        <= 1'b1;
         lvl           <= 3'd0;
         spurious      <= 1'b0;
         int_o         <= 1'b0;
         isr_set       <= 1'b0;
         isr_set_level <= 3'd0;
         isr_clr       <= 8'd0;
         data_out      <= 8'd0;
         data_oe       <= 1'b0;
         prio_base     <= 3'd7;
      end else begin
         inta_q  <= inta_n;
         isr_set <= 1'b0;
         isr_clr <= eoi_mask | aeoi_mask;

         // AEOI rotation wins over a coincident EOI rotation.
         if (aeoi_fire && rot_en)
            prio_base <= lvl;
         else if (eoi_hit && rot_en)
            prio_base <= eoi_sel;

         case (state)
            IDLE: begin
               if (req_valid) begin
                  int_o <= 1'b1;
                  state <= PEND;
               end
            end
            PEND: begin
               if (fall) begin
                  if (req_valid) begin
                     lvl           <= req_level;
                     spurious      <= 1'b0;
                     isr_set       <= 1'b1;
                     isr_set_level <= req_level;
                  end else begin
                     // Request vanished before the acknowledge: report IR7.
                     lvl      <= 3'd7;
                     spurious <= 1'b1;
                  end
                  state <= ACK1;
               end
            end
            ACK1: begin
               data_oe <= 1'b0;
               if (fall) begin
                  data_out <= {vec_base, lvl};
                  data_oe  <= 1'b1;
                  state    <= ACK2;
               end
            end
            ACK2: begin
               if (rise) begin
                  data_oe <= 1'b0;
                  int_o   <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// tb/tb_pic_inta_sequencer.sv - randomized self-checking bench for pic_inta_sequencer

module tb_pic_inta_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0;
   logic [2:0] req_level = 3'd0;
   logic       inta_n = 1'b1;
   logic [4:0] vec_base = 5'd0;
   logic       aeoi = 1'b0;
   logic       rot_en = 1'b0;
   logic       eoi_cmd = 1'b0;
   logic       eoi_specific = 1'b0;
   logic [2:0] eoi_level = 3'd0;
   logic [7:0] isr = 8'd0;
   logic       int_o;
   logic       isr_set;
   logic [2:0] isr_set_level;
   logic [7:0] isr_clr;
   logic [7:0] data_out;
   logic       data_oe;
   logic [2:0] prio_base;

`ifdef PIC_AEOI_EN
   localparam bit AEOI_BUILT = 1'b1;
`else
   localparam bit AEOI_BUILT = 1'b0;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   // reference state: priority base and the in-service register the bench keeps
   int         m_pb = 7;
   logic [7:0] m_isr = 8'd0;

   pic_inta_sequencer dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_level(req_level),
      .inta_n(inta_n), .vec_base(vec_base), .aeoi(aeoi), .rot_en(rot_en),
      .eoi_cmd(eoi_cmd), .eoi_specific(eoi_specific), .eoi_level(eoi_level),
      .isr(isr), .int_o(int_o), .isr_set(isr_set), .isr_set_level(isr_set_level),
      .isr_clr(isr_clr), .data_out(data_out), .data_oe(data_oe), .prio_base(prio_base)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // highest-priority set bit counting from pb+1 around the ring, -1 if none
   function automatic int ns_pick(input logic [7:0] v, input int pb);
      for (int k = 1; k <= 8; k++) begin
         if (v[(pb + k) % 8]) return (pb + k) % 8;
      end
      return -1;
   endfunction

   task automatic settle();
      tick();
      check_eq("clr_one_cycle", isr_clr, 8'd0);
      check_eq("set_idle", isr_set, 1'b0);
   endtask

   task automatic do_eoi(input bit spec, input logic [2:0] lv);
      int         hit;
      logic [7:0] mask;
      eoi_cmd = 1'b1;
      eoi_specific = spec;
      eoi_level = lv;
      isr = m_isr;
      hit = spec ? int'(lv) : ns_pick(m_isr, m_pb);
      mask = (hit >= 0) ? (8'd1 << hit) : 8'd0;
      tick();
      eoi_cmd = 1'b0;
      check_eq(spec ? "eoi_spec_clr" : "eoi_ns_clr", isr_clr, mask);
      if (hit >= 0 && rot_en) m_pb = hit;
      check_eq("eoi_prio_base", prio_base, m_pb);
      m_isr = m_isr & ~mask;
      isr = m_isr;
   endtask

   task automatic do_ack(input bit spur, input logic [2:0] lv, input bit co, input logic [2:0] co_lv);
      logic [2:0] vl;
      logic [7:0] mask;
      bit         afire;
      req_valid = 1'b1;
      req_level = lv;
      tick();
      check_eq("int_raise", int_o, 1'b1);
      repeat ($urandom_range(0, 2)) begin
         tick();
         check_eq("int_hold", int_o, 1'b1);
      end
      if (spur) req_valid = 1'b0;
      inta_n = 1'b0;
      tick();
      check_eq("first_set", isr_set, !spur);
      check_eq("first_oe", data_oe, 1'b0);
      if (!spur) begin
         check_eq("first_level", isr_set_level, lv);
         m_isr[lv] = 1'b1;
         isr = m_isr;
      end
      req_valid = 1'($urandom);
      req_level = 3'($urandom);
      inta_n = 1'b1;
      tick();
      check_eq("set_pulse_end", isr_set, 1'b0);
      check_eq("ack1_oe", data_oe, 1'b0);
      repeat ($urandom_range(0, 2)) begin
         tick();
         check_eq("ack1_oe_hold", data_oe, 1'b0);
      end
      inta_n = 1'b0;
      tick();
      vl = spur ? 3'd7 : lv;
      check_eq("vec_oe", data_oe, 1'b1);
      check_eq("vector", data_out, vec_base * 8 + vl);
      repeat ($urandom_range(0, 2)) begin
         tick();
         check_eq("vec_oe_hold", data_oe, 1'b1);
      end
      inta_n = 1'b1;
      req_valid = 1'b0;
      if (co) begin
         eoi_cmd = 1'b1;
         eoi_specific = 1'b1;
         eoi_level = co_lv;
      end
      tick();
      eoi_cmd = 1'b0;
      afire = AEOI_BUILT && aeoi && !spur;
      mask = (afire ? (8'd1 << lv) : 8'd0) | (co ? (8'd1 << co_lv) : 8'd0);
      check_eq("exit_oe", data_oe, 1'b0);
      check_eq("exit_int", int_o, 1'b0);
      check_eq("exit_clr", isr_clr, mask);
      if (rot_en) begin
         if (afire) m_pb = lv;
         else if (co) m_pb = co_lv;
      end
      check_eq("exit_prio_base", prio_base, m_pb);
      m_isr = m_isr & ~mask;
      isr = m_isr;
      settle();
   endtask

   task automatic idle_noise();
      req_valid = 1'b0;
      repeat (4) begin
         inta_n = 1'($urandom);
         tick();
         check_eq("idle_int", int_o, 1'b0);
         check_eq("idle_oe", data_oe, 1'b0);
         check_eq("idle_set", isr_set, 1'b0);
      end
      inta_n = 1'b1;
      tick();
   endtask

   initial begin
      // reset
      repeat (3) tick();
      check_eq("rst_int", int_o, 1'b0);
      check_eq("rst_oe", data_oe, 1'b0);
      rst_n = 1'b1;
      tick();
      check_eq("rst_int_rel", int_o, 1'b0);
      check_eq("rst_oe_rel", data_oe, 1'b0);
      check_eq("rst_prio_base", prio_base, 3'd7);
      check_eq("rst_clr", isr_clr, 8'd0);
      check_eq("rst_data", data_out, 8'd0);

      // normal acknowledge: vector 0x43
      vec_base = 5'b01000;
      do_ack(1'b0, 3'd3, 1'b0, 3'd0);

      // spurious acknowledge with AEOI requested
      aeoi = 1'b1;
      rot_en = 1'b1;
      do_ack(1'b1, 3'd5, 1'b0, 3'd0);

      // move base to 3, then non-specific EOI with rotation
      do_eoi(1'b1, 3'd3);
      settle();
      m_isr = 8'b0010_0100;
      do_eoi(1'b0, 3'd0);
      settle();
      m_isr = 8'd0;
      do_eoi(1'b0, 3'd0);
      settle();

      // AEOI with a coincident specific EOI for level 6
      m_isr = 8'h40;
      isr = m_isr;
      do_ack(1'b0, 3'd2, 1'b1, 3'd6);

      // back-to-back non-specific EOIs
      m_isr = 8'hA5;
      do_eoi(1'b0, 3'd0);
      do_eoi(1'b0, 3'd0);
      settle();

      idle_noise();

      // randomized mix
      for (int it = 0; it < 40; it++) begin
         vec_base = 5'($urandom);
         aeoi = 1'($urandom);
         rot_en = 1'($urandom);
         if ($urandom_range(0, 3) == 0) m_isr = m_isr | 8'($urandom);
         isr = m_isr;
         case ($urandom_range(0, 2))
            0: do_ack($urandom_range(0, 3) == 0, 3'($urandom), $urandom_range(0, 2) == 0, 3'($urandom));
            1: begin do_eoi(1'b1, 3'($urandom)); settle(); end
            default: begin do_eoi(1'b0, 3'd0); settle(); end
         endcase
      end

      // reset in the middle of the acknowledge
      req_valid = 1'b1;
      req_level = 3'd4;
      tick();
      inta_n = 1'b0;
      tick();
      inta_n = 1'b1;
      tick();
      inta_n = 1'b0;
      tick();
      check_eq("mid_oe_before", data_oe, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("mid_oe_async", data_oe, 1'b0);
      check_eq("mid_int_async", int_o, 1'b0);
      req_valid = 1'b0;
      inta_n = 1'b1;
      tick();
      rst_n = 1'b1;
      m_pb = 7;
      tick();
      check_eq("mid_prio_base", prio_base, 3'd7);
      check_eq("mid_int_idle", int_o, 1'b0);
      aeoi = 1'b0;
      vec_base = 5'b10101;
      do_ack(1'b0, 3'd1, 1'b0, 3'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
